// File: rtl/vram_arbiter.sv
// Two-master arbiter for the 16-bit video RAM port: video fetcher has priority,
// the owner keeps the grant until it drops CYC, and a watchdog ends unacked strobes.
module vram_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [13:1] V_ADR_I,
  input  logic        V_CYC_I,
  input  logic        V_STB_I,
  output logic [15:0] V_DAT_O,
  output logic        V_ACK_O,
  input  logic [13:1] C_ADR_I,
  input  logic [15:0] C_DAT_I,
  output logic [15:0] C_DAT_O,
  input  logic        C_WE_I,
  input  logic [1:0]  C_SEL_I,
  input  logic        C_CYC_I,
  input  logic        C_STB_I,
  output logic        C_ACK_O,
  output logic [13:1] M_ADR_O,
  output logic [15:0] M_DAT_O,
  input  logic [15:0] M_DAT_I,
  output logic        M_WE_O,
  output logic [1:0]  M_SEL_O,
  output logic        M_CYC_O,
  output logic        M_STB_O,
  input  logic        M_ACK_I,
  output logic [1:0]  GNT_O,
  output logic        TOERR_O
);

  // Encoding matches GNT_O so the state register is directly observable.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_VID  = 2'b01,
    GNT_CPU  = 2'b10
  } gnt_t;

  localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

  gnt_t       gnt, gnt_nxt;
  logic [7:0] wdt, wdt_nxt;
  logic       term;
  logic       done;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      gnt <= GNT_IDLE;
      wdt <= 8'd0;
    end else begin
      gnt <= gnt_nxt;
      wdt <= wdt_nxt;
    end
  end

  // Handover between owners is direct; no idle cycle is inserted.
  always_comb begin
    gnt_nxt = gnt;
    case (gnt)
      GNT_IDLE: begin
        if (V_CYC_I)      gnt_nxt = GNT_VID;
        else if (C_CYC_I) gnt_nxt = GNT_CPU;
      end
      GNT_VID: if (!V_CYC_I) gnt_nxt = C_CYC_I ? GNT_CPU : GNT_IDLE;
      GNT_CPU: if (!C_CYC_I) gnt_nxt = V_CYC_I ? GNT_VID : GNT_IDLE;
      default: gnt_nxt = GNT_IDLE;
    endcase
  end

  always_comb begin
    M_ADR_O = '0;
    M_WE_O  = 1'b0;
    M_SEL_O = 2'b00;
    M_CYC_O = 1'b0;
    M_STB_O = 1'b0;
    case (gnt)
      GNT_VID: begin
        M_ADR_O = V_ADR_I;
        M_SEL_O = 2'b11;
        M_CYC_O = V_CYC_I;
        M_STB_O = V_CYC_I & V_STB_I;
      end
      GNT_CPU: begin
        M_ADR_O = C_ADR_I;
        M_WE_O  = C_WE_I;
        M_SEL_O = C_SEL_I;
        M_CYC_O = C_CYC_I;
        M_STB_O = C_CYC_I & C_STB_I;
      end
      default: ;
    endcase
  end

  // A real ack at the terminal count takes precedence over the forced one.
  // A terminated write never received a slave ack, so nothing was committed.
  assign term    = M_STB_O && !M_ACK_I && (wdt == WDT_LAST);
  assign done    = M_ACK_I | term;
  assign wdt_nxt = (!M_STB_O || M_ACK_I || term) ? 8'd0 : wdt + 8'd1;

  assign V_ACK_O = (gnt == GNT_VID) && V_CYC_I && V_STB_I && done;
  assign C_ACK_O = (gnt == GNT_CPU) && C_CYC_I && C_STB_I && done;
  assign V_DAT_O = (term && gnt == GNT_VID) ? 16'hFFFF : M_DAT_I;
  assign C_DAT_O = (term && gnt == GNT_CPU) ? 16'hFFFF : M_DAT_I;
  assign M_DAT_O = C_DAT_I;
  assign GNT_O   = gnt;
  assign TOERR_O = term;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: grant order, bursts, CPU write routing,
// no-preemption, watchdog termination and asynchronous reset.
module tb_vram_arbiter;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [13:1] V_ADR_I;
  logic        V_CYC_I, V_STB_I;
  logic [15:0] V_DAT_O;
  logic        V_ACK_O;
  logic [13:1] C_ADR_I;
  logic [15:0] C_DAT_I, C_DAT_O;
  logic        C_WE_I;
  logic [1:0]  C_SEL_I;
  logic        C_CYC_I, C_STB_I, C_ACK_O;
  logic [13:1] M_ADR_O;
  logic [15:0] M_DAT_O, M_DAT_I;
  logic        M_WE_O;
  logic [1:0]  M_SEL_O;
  logic        M_CYC_O, M_STB_O, M_ACK_I;
  logic [1:0]  GNT_O;
  logic        TOERR_O;

  int vectors = 0;
  int miscompares = 0;
  int v_acks = 0;
  int c_acks = 0;
  logic [15:0] exp_q[$];

  vram_arbiter #(.TIMEOUT(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .V_ADR_I(V_ADR_I), .V_CYC_I(V_CYC_I), .V_STB_I(V_STB_I),
    .V_DAT_O(V_DAT_O), .V_ACK_O(V_ACK_O),
    .C_ADR_I(C_ADR_I), .C_DAT_I(C_DAT_I), .C_DAT_O(C_DAT_O),
    .C_WE_I(C_WE_I), .C_SEL_I(C_SEL_I), .C_CYC_I(C_CYC_I),
    .C_STB_I(C_STB_I), .C_ACK_O(C_ACK_O),
    .M_ADR_O(M_ADR_O), .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I),
    .M_WE_O(M_WE_O), .M_SEL_O(M_SEL_O), .M_CYC_O(M_CYC_O),
    .M_STB_O(M_STB_O), .M_ACK_I(M_ACK_I),
    .GNT_O(GNT_O), .TOERR_O(TOERR_O)
  );

  // Clock / reset
  always #5 CLK_I = ~CLK_I;

  // Inputs change 2 ns after the rising edge; outputs are sampled 3 ns later.
  task automatic tick();
    @(posedge CLK_I);
    #2;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expected read word per ack seen by either master.
  task automatic sample_acks();
    logic [15:0] e;
    if (V_ACK_O) begin
      v_acks++;
      chk("sb_v_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_v_dat", V_DAT_O, e);
      end
    end
    if (C_ACK_O) begin
      c_acks++;
      chk("sb_c_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_c_dat", C_DAT_O, e);
      end
    end
  endtask

  initial begin
    RST_I = 1'b0;
    V_ADR_I = '0; V_CYC_I = 1'b1; V_STB_I = 1'b1;
    C_ADR_I = '0; C_DAT_I = '0; C_WE_I = 1'b0; C_SEL_I = 2'b00;
    C_CYC_I = 1'b1; C_STB_I = 1'b1;
    M_DAT_I = '0; M_ACK_I = 1'b1;

    // Reset held with both requests high
    repeat (3) tick();
    settle();
    chk("rst_gnt", GNT_O, 2'b00);
    chk("rst_mcyc", M_CYC_O, 0);
    chk("rst_mstb", M_STB_O, 0);
    chk("rst_vack", V_ACK_O, 0);
    chk("rst_cack", C_ACK_O, 0);
    chk("rst_toerr", TOERR_O, 0);
    chk("rst_madr", M_ADR_O, 0);
    tick();
    M_ACK_I = 1'b0;
    RST_I = 1'b1;
    settle();
    chk("rel_gnt_before", GNT_O, 2'b00);
    tick();
    settle();
    chk("rel_gnt_after", GNT_O, 2'b01);
    tick();
    V_CYC_I = 1'b0; V_STB_I = 1'b0; C_CYC_I = 1'b0; C_STB_I = 1'b0;
    tick();
    settle();
    chk("idle_gnt", GNT_O, 2'b00);

    // Collision in IDLE, then a 40-beat video burst
    tick();
    V_CYC_I = 1'b1; V_STB_I = 1'b1; C_CYC_I = 1'b1; C_STB_I = 1'b1;
    tick();
    settle();
    chk("coll_gnt", GNT_O, 2'b01);
    chk("coll_we", M_WE_O, 0);
    chk("coll_sel", M_SEL_O, 2'b11);
    v_acks = 0; c_acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      V_ADR_I = 13'(i * 7 + 3);
      M_DAT_I = 16'($urandom_range(0, 16'hFFFF));
      M_ACK_I = 1'b1;
      exp_q.push_back(M_DAT_I);
      settle();
      if (i == 5) chk("burst_madr", M_ADR_O, 13'(5 * 7 + 3));
      sample_acks();
    end
    chk("burst_vacks", v_acks, 40);
    chk("burst_cacks", c_acks, 0);
    chk("burst_q_empty", exp_q.size(), 0);
    tick();
    V_CYC_I = 1'b0; V_STB_I = 1'b0; M_ACK_I = 1'b0;
    settle();
    chk("vdrop_gnt_hold", GNT_O, 2'b01);
    tick();
    settle();
    chk("vdrop_gnt_cpu", GNT_O, 2'b10);

    // CPU write routing and combinational ack
    tick();
    C_ADR_I = 13'h0123; C_DAT_I = 16'hA55A; C_SEL_I = 2'b10; C_WE_I = 1'b1;
    settle();
    chk("wr_we", M_WE_O, 1);
    chk("wr_sel", M_SEL_O, 2'b10);
    chk("wr_adr", M_ADR_O, 13'h0123);
    chk("wr_dat", M_DAT_O, 16'hA55A);
    chk("wr_cack_low", C_ACK_O, 0);
    M_ACK_I = 1'b1;
    #1;
    chk("wr_cack_comb", C_ACK_O, 1);
    chk("wr_vack", V_ACK_O, 0);
    tick();
    M_ACK_I = 1'b0; C_WE_I = 1'b0; C_SEL_I = 2'b11;

    // No preemption: CPU keeps the bus across 3 beats while video requests
    V_CYC_I = 1'b1; V_STB_I = 1'b1;
    c_acks = 0; v_acks = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      M_DAT_I = 16'($urandom_range(0, 16'hFFFF));
      M_ACK_I = 1'b1;
      exp_q.push_back(M_DAT_I);
      settle();
      chk("nopre_gnt", GNT_O, 2'b10);
      sample_acks();
    end
    chk("nopre_cacks", c_acks, 3);
    chk("nopre_vacks", v_acks, 0);
    tick();
    C_CYC_I = 1'b0; C_STB_I = 1'b0; M_ACK_I = 1'b0;
    settle();
    chk("nopre_gnt_hold", GNT_O, 2'b10);
    tick();
    settle();
    chk("nopre_gnt_vid", GNT_O, 2'b01);

    // Watchdog: slave never acks; forced ack in cycle 16
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) exp_q.push_back(16'hFFFF);
      settle();
      sample_acks();
      if (k < 16) begin
        chk("wdt_no_ack", V_ACK_O, 0);
        chk("wdt_no_toerr", TOERR_O, 0);
      end else begin
        chk("wdt_ack", V_ACK_O, 1);
        chk("wdt_dat", V_DAT_O, 16'hFFFF);
        chk("wdt_toerr", TOERR_O, 1);
      end
      tick();
    end
    // Real ack arriving at the terminal count wins
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        M_DAT_I = 16'h1234;
        M_ACK_I = 1'b1;
        exp_q.push_back(16'h1234);
      end
      settle();
      sample_acks();
      if (k == 16) begin
        chk("wdt_real_ack", V_ACK_O, 1);
        chk("wdt_real_dat", V_DAT_O, 16'h1234);
        chk("wdt_real_toerr", TOERR_O, 0);
      end
      tick();
    end
    M_ACK_I = 1'b0;
    chk("wdt_q_empty", exp_q.size(), 0);

    // Asynchronous reset between edges during a video burst
    M_ACK_I = 1'b1; V_ADR_I = 13'h1ABC;
    settle();
    chk("arst_pre_cyc", M_CYC_O, 1);
    #1;
    RST_I = 1'b0;
    #1;
    chk("arst_mcyc", M_CYC_O, 0);
    chk("arst_mstb", M_STB_O, 0);
    chk("arst_madr", M_ADR_O, 0);
    chk("arst_gnt", GNT_O, 2'b00);
    chk("arst_vack", V_ACK_O, 0);
    tick();
    RST_I = 1'b1; M_ACK_I = 1'b0;
    tick();
    settle();
    chk("arst_regrant", GNT_O, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
